// File: rtl/fnn_weight_loader_pkg.sv
// Shared constants, FSM encoding and layer-shape helpers for the FNN weight loader.
package fnn_weight_loader_pkg;

  localparam int WEIGHT_WIDTH  = 16;
  localparam int PART_NO_WIDTH = 7;
  localparam int ADDR_WIDTH    = 10;
  localparam int NO_OF_INPUTS  = 784;
  localparam int NN1 = 40;
  localparam int NN2 = 10;
  localparam int NN3 = 10;
  localparam int NN4 = 10;

  localparam int NUM_PARTS   = NN1 + NN2 + NN3 + NN4;
  // Each neuron carries fan_in weights followed by one bias word.
  localparam int TOTAL_WORDS = NN1 * (NO_OF_INPUTS + 1) + NN2 * (NN1 + 1)
                             + NN3 * (NN2 + 1) + NN4 * (NN3 + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  // Fan-in of a layer; this is also the address of that layer's bias word.
  function automatic logic [ADDR_WIDTH-1:0] fan_in_of(input logic [1:0] layer);
    case (layer)
      2'd0:    return ADDR_WIDTH'(NO_OF_INPUTS);
      2'd1:    return ADDR_WIDTH'(NN1);
      2'd2:    return ADDR_WIDTH'(NN2);
      default: return ADDR_WIDTH'(NN3);
    endcase
  endfunction

  // Number of neurons in a layer.
  function automatic logic [PART_NO_WIDTH-1:0] neurons_of(input logic [1:0] layer);
    case (layer)
      2'd0:    return PART_NO_WIDTH'(NN1);
      2'd1:    return PART_NO_WIDTH'(NN2);
      2'd2:    return PART_NO_WIDTH'(NN3);
      default: return PART_NO_WIDTH'(NN4);
    endcase
  endfunction

endpackage

// File: rtl/fnn_part_counter.sv
// Position tracker for the weight stream: (layer, neuron-in-layer, addr) plus the
// global neuron index that the next word must be tagged with.
module fnn_part_counter
  import fnn_weight_loader_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     advance,
  output logic [1:0]               layer,
  output logic [PART_NO_WIDTH-1:0] neuron,
  output logic [ADDR_WIDTH-1:0]    addr,
  output logic [PART_NO_WIDTH-1:0] part,
  output logic                     last_in_neuron,
  output logic                     last_word
);

  assign last_in_neuron = (addr == fan_in_of(layer));
  assign last_word      = last_in_neuron && (part == PART_NO_WIDTH'(NUM_PARTS - 1));

  // Step one word forward; after a bias move to the next neuron / layer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      layer  <= '0;
      neuron <= '0;
      addr   <= '0;
      part   <= '0;
    end else if (clear) begin
      layer  <= '0;
      neuron <= '0;
      addr   <= '0;
      part   <= '0;
    end else if (advance) begin
      if (last_in_neuron) begin
        addr <= '0;
        part <= part + 1'b1;
        if (neuron == neurons_of(layer) - 1'b1) begin
          neuron <= '0;
          layer  <= layer + 2'd1;
        end else begin
          neuron <= neuron + 1'b1;
        end
      end else begin
        addr <= addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fnn_weight_loader.sv
// Receive side of the FNN weight-load stream: checks tags against the expected
// neuron order and issues registered single-cycle writes to the layer RAMs.
//
// Handshake: a word is consumed on a rising clk edge when the FSM is in LOAD,
// load_weights=1 and weight_valid=1; there is no backpressure. A consumed word whose
// tag matches produces wr_en=1 for exactly one cycle on the following cycle.
module fnn_weight_loader
  import fnn_weight_loader_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   restart,
  input  logic                                   load_weights,
  input  logic                                   weight_valid,
  input  logic [0:WEIGHT_WIDTH+PART_NO_WIDTH-1]  weight_bus,
  output logic                                   wr_en,
  output logic [1:0]                             wr_layer,
  output logic [PART_NO_WIDTH-1:0]               wr_neuron,
  output logic [ADDR_WIDTH-1:0]                  wr_addr,
  output logic                                   wr_is_bias,
  output logic [WEIGHT_WIDTH-1:0]                wr_data,
  output logic                                   FNN_ready,
  output logic                                   load_error,
  output logic [1:0]                             fsm_state
);

  state_t                     state;
  logic                       load_q;
  logic                       rise;
  logic                       start;
  logic                       part_ok;
  logic                       accept;
  logic [PART_NO_WIDTH-1:0]   part_in;
  logic [WEIGHT_WIDTH-1:0]    data_in;
  logic [1:0]                 cnt_layer;
  logic [PART_NO_WIDTH-1:0]   cnt_neuron;
  logic [ADDR_WIDTH-1:0]      cnt_addr;
  logic [PART_NO_WIDTH-1:0]   exp_part;
  logic                       last_in_neuron;
  logic                       last_word;

  // Bus is declared big-endian: tag occupies the leading bits, weight the rest.
  assign part_in = weight_bus[0:PART_NO_WIDTH-1];
  assign data_in = weight_bus[PART_NO_WIDTH:WEIGHT_WIDTH+PART_NO_WIDTH-1];

  assign rise      = load_weights & ~load_q;
  assign start     = rise & (state != ST_LOAD);
  assign part_ok   = (part_in == exp_part);
  assign accept    = (state == ST_LOAD) & load_weights & weight_valid & part_ok;
  assign fsm_state = state;

  fnn_part_counter u_counter (
    .clk            (clk),
    .rst            (restart),
    .clear          (start),
    .advance        (accept),
    .layer          (cnt_layer),
    .neuron         (cnt_neuron),
    .addr           (cnt_addr),
    .part           (exp_part),
    .last_in_neuron (last_in_neuron),
    .last_word      (last_word)
  );

  // Session FSM with registered write port and status flags.
  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      state      <= ST_IDLE;
      load_q     <= 1'b0;
      wr_en      <= 1'b0;
      wr_layer   <= '0;
      wr_neuron  <= '0;
      wr_addr    <= '0;
      wr_is_bias <= 1'b0;
      wr_data    <= '0;
      FNN_ready  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      load_q <= load_weights;
      wr_en  <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          // Words arriving here are dropped; the edge cycle itself never accepts.
          if (rise) begin
            state      <= ST_LOAD;
            FNN_ready  <= 1'b0;
            load_error <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (!load_weights) begin
            state      <= ST_ERR;
            load_error <= 1'b1;
          end else if (weight_valid) begin
            if (part_ok) begin
              wr_en      <= 1'b1;
              wr_layer   <= cnt_layer;
              wr_neuron  <= cnt_neuron;
              wr_addr    <= cnt_addr;
              wr_is_bias <= last_in_neuron;
              wr_data    <= data_in;
              if (last_word) begin
                state     <= ST_DONE;
                FNN_ready <= 1'b1;
              end
            end else begin
              state      <= ST_ERR;
              load_error <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fnn_weight_loader.sv
// Directed bench for fnn_weight_loader with a write scoreboard.
module tb_fnn_weight_loader;
  import fnn_weight_loader_pkg::*;

  localparam int EW = 37; // {ready, layer, neuron, addr, bias, data}

  logic                                  clk;
  logic                                  restart;
  logic                                  load_weights;
  logic                                  weight_valid;
  logic [0:WEIGHT_WIDTH+PART_NO_WIDTH-1] weight_bus;
  logic                                  wr_en;
  logic [1:0]                            wr_layer;
  logic [PART_NO_WIDTH-1:0]              wr_neuron;
  logic [ADDR_WIDTH-1:0]                 wr_addr;
  logic                                  wr_is_bias;
  logic [WEIGHT_WIDTH-1:0]               wr_data;
  logic                                  FNN_ready;
  logic                                  load_error;
  logic [1:0]                            fsm_state;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] last_wr;
  int            checks;
  int            failures;
  int            wr_count;
  int            full_words;

  int nn_tab[4]   = '{40, 10, 10, 10};
  int fi_tab[4]   = '{784, 40, 10, 10};
  int base_tab[4] = '{0, 40, 50, 60};

  fnn_weight_loader dut (
    .clk          (clk),
    .restart      (restart),
    .load_weights (load_weights),
    .weight_valid (weight_valid),
    .weight_bus   (weight_bus),
    .wr_en        (wr_en),
    .wr_layer     (wr_layer),
    .wr_neuron    (wr_neuron),
    .wr_addr      (wr_addr),
    .wr_is_bias   (wr_is_bias),
    .wr_data      (wr_data),
    .FNN_ready    (FNN_ready),
    .load_error   (load_error),
    .fsm_state    (fsm_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every write seen on the falling edge is matched against the queue.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      logic [EW-1:0] obs;
      logic [EW-1:0] e;
      obs = {FNN_ready, wr_layer, wr_neuron, wr_addr, wr_is_bias, wr_data};
      last_wr = obs;
      wr_count++;
      checks++;
      if (exp_q.size() == 0) begin
        assert (0) else begin
          failures++;
          $error("FAIL unexpected_write observed=%0h expected=none", obs);
        end
      end else begin
        e = exp_q.pop_front();
        assert (obs === e) else begin
          failures++;
          $error("FAIL write observed=%0h expected=%0h", obs, e);
        end
      end
    end
  end

  // Driver: walk the stream in order; optional 1-on/2-off gaps for the first
  // gap_words words; word bad_idx gets tag bad_part and everything after it is
  // expected to be dropped.
  task automatic stream(input int n_words, input int gap_words, input int bad_idx,
                        input int bad_part);
    int  k;
    bit  dead;
    logic [15:0] data;
    logic [6:0]  part;
    k = 0;
    dead = 0;
    for (int l = 0; l < 4; l++) begin
      for (int n = 0; n < nn_tab[l]; n++) begin
        for (int a = 0; a <= fi_tab[l]; a++) begin
          if (k >= n_words) begin
            weight_valid = 1'b0;
            return;
          end
          data = 16'($urandom_range(0, 65535));
          part = (k == bad_idx) ? 7'(bad_part) : 7'(base_tab[l] + n);
          weight_valid = 1'b1;
          weight_bus   = {part, data};
          if (!dead && k != bad_idx)
            exp_q.push_back({(l == 3 && n == 9 && a == 10) ? 1'b1 : 1'b0,
                             2'(l), 7'(n), 10'(a), (a == fi_tab[l]) ? 1'b1 : 1'b0, data});
          tick();
          if (k == bad_idx) begin
            dead = 1;
            chk("mismatch_err_next", {63'd0, load_error}, 64'd1);
            chk("mismatch_state_err", {62'd0, fsm_state}, 64'(ST_ERR));
          end
          if (k < gap_words) begin
            weight_valid = 1'b0;
            weight_bus   = 23'($urandom());
            repeat (2) tick();
          end
          k++;
        end
      end
    end
    weight_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    wr_count = 0;
    last_wr = '0;
    full_words = 0;
    for (int l = 0; l < 4; l++) full_words += nn_tab[l] * (fi_tab[l] + 1);

    restart = 1'b1;
    load_weights = 1'b0;
    weight_valid = 1'b0;
    weight_bus = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
    chk("rst_wr_layer", {62'd0, wr_layer}, 64'd0);
    chk("rst_wr_neuron", {57'd0, wr_neuron}, 64'd0);
    chk("rst_wr_addr", {54'd0, wr_addr}, 64'd0);
    chk("rst_wr_is_bias", {63'd0, wr_is_bias}, 64'd0);
    chk("rst_wr_data", {48'd0, wr_data}, 64'd0);
    chk("rst_ready", {63'd0, FNN_ready}, 64'd0);
    chk("rst_error", {63'd0, load_error}, 64'd0);
    chk("rst_state", {62'd0, fsm_state}, 64'(ST_IDLE));
    restart = 1'b0;
    tick();

    // Valid while IDLE is ignored
    weight_valid = 1'b1;
    weight_bus = {7'd0, 16'h1234};
    repeat (2) tick();
    weight_valid = 1'b0;
    tick();
    chk("idle_state", {62'd0, fsm_state}, 64'(ST_IDLE));
    chk("idle_error", {63'd0, load_error}, 64'd0);

    // Tag mismatch on the first word of neuron 1
    load_weights = 1'b1;
    tick();
    chk("start_state_load", {62'd0, fsm_state}, 64'(ST_LOAD));
    stream(796, 0, 785, 5);
    chk("mismatch_error_held", {63'd0, load_error}, 64'd1);
    chk("mismatch_ready", {63'd0, FNN_ready}, 64'd0);
    chk("mismatch_q_empty", 64'(exp_q.size()), 64'd0);

    // New session from ERR, then abort after 1000 words
    load_weights = 1'b0;
    tick();
    load_weights = 1'b1;
    tick();
    chk("restart_err_cleared", {63'd0, load_error}, 64'd0);
    chk("restart_state_load", {62'd0, fsm_state}, 64'(ST_LOAD));
    stream(1000, 0, -1, 0);
    load_weights = 1'b0;
    tick();
    chk("abort_error", {63'd0, load_error}, 64'd1);
    chk("abort_ready", {63'd0, FNN_ready}, 64'd0);
    chk("abort_state", {62'd0, fsm_state}, 64'(ST_ERR));
    chk("abort_q_empty", 64'(exp_q.size()), 64'd0);

    // Valid on the rising-edge cycle is not accepted; gapped prefix; restart at 20000
    weight_valid = 1'b1;
    weight_bus = {7'd0, 16'h5555};
    load_weights = 1'b1;
    tick();
    weight_valid = 1'b0;
    chk("edge_state_load", {62'd0, fsm_state}, 64'(ST_LOAD));
    stream(20000, 900, -1, 0);
    chk("partial_ready", {63'd0, FNN_ready}, 64'd0);
    chk("partial_error", {63'd0, load_error}, 64'd0);
    @(negedge clk);
    #1;
    restart = 1'b1;
    #1;
    chk("async_wr_en", {63'd0, wr_en}, 64'd0);
    chk("async_wr_addr", {54'd0, wr_addr}, 64'd0);
    chk("async_wr_data", {48'd0, wr_data}, 64'd0);
    chk("async_state", {62'd0, fsm_state}, 64'(ST_IDLE));
    chk("async_ready", {63'd0, FNN_ready}, 64'd0);
    load_weights = 1'b0;
    tick();
    restart = 1'b0;
    tick();
    chk("restart_q_empty", 64'(exp_q.size()), 64'd0);

    // Full continuous reload
    wr_count = 0;
    load_weights = 1'b1;
    tick();
    stream(100000, 0, -1, 0);
    chk("full_ready", {63'd0, FNN_ready}, 64'd1);
    chk("full_error", {63'd0, load_error}, 64'd0);
    chk("full_state", {62'd0, fsm_state}, 64'(ST_DONE));
    @(negedge clk);
    #1;
    chk("last_layer", {62'd0, last_wr[35:34]}, 64'd3);
    chk("last_neuron", {57'd0, last_wr[33:27]}, 64'd9);
    chk("last_addr", {54'd0, last_wr[26:17]}, 64'd10);
    chk("last_bias", {63'd0, last_wr[16]}, 64'd1);

    // Trailing valid words with undefined data after completion
    tick();
    weight_valid = 1'b1;
    weight_bus = 'x;
    repeat (2) tick();
    weight_valid = 1'b0;
    weight_bus = '0;
    repeat (2) tick();
    chk("trail_ready", {63'd0, FNN_ready}, 64'd1);
    chk("trail_error", {63'd0, load_error}, 64'd0);
    chk("trail_state", {62'd0, fsm_state}, 64'(ST_DONE));
    chk("full_write_count", 64'(wr_count), 64'(full_words));
    chk("full_q_empty", 64'(exp_q.size()), 64'd0);

    // A new session drops FNN_ready
    load_weights = 1'b0;
    tick();
    load_weights = 1'b1;
    tick();
    chk("new_session_ready", {63'd0, FNN_ready}, 64'd0);
    chk("new_session_state", {62'd0, fsm_state}, 64'(ST_LOAD));
    load_weights = 1'b0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
